// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial add/subtract sequencer.
package serial_adder_ctrl_pkg;

    // Operand / result width used when the instantiating level does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_fulladder.sv
// Ripple full adder: s = a + b + y, with carry-out c.
// The sequencer uses it with WIDTH=1 as its single serial adder cell.
module fulladder #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             y,
    output logic             c,
    output logic [WIDTH-1:0] s
);

    logic [WIDTH:0] carry;

    assign carry[0] = y;

    // One full-adder bit per position, carry rippling upward.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign s[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c = carry[WIDTH];

endmodule : fulladder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer. Operands are latched on an accepted start,
// then fed LSB-first through one 1-bit full adder, one bit per clock. Subtraction
// is a + ~b + 1, so the carry flop is seeded with sub and cout=1 means no borrow.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [0:0]       fa_s;
    logic             fa_c;

    // The single adder cell works on the current LSBs and the stored carry.
    fulladder #(
        .WIDTH (1)
    ) u_fa (
        .a (a_sh_q[0:0]),
        .b (b_sh_q[0:0]),
        .y (carry_q),
        .c (fa_c),
        .s (fa_s)
    );

    // Next-state, operand loading and per-bit shifting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // start is deliberately not looked at here: a running operation is never disturbed.
                carry_d = fa_c;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_c;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder_ctrl
